// File: rtl/flit_stream_arbiter.sv
// Round-robin flit stream merger with per-message locking and a one-entry registered output slot.
// State updates on the falling clock edge; reset is synchronous and active-low.
module flit_stream_arbiter #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned LOG_NUM_IN = 2,
    parameter int unsigned FLIT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN*FLIT_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         locked,
    output logic [LOG_NUM_IN-1:0]        lock_owner
);

    logic [FLIT_WIDTH-1:0] data_q, data_d;
    logic                  full_q, full_d;
    logic                  locked_q, locked_d;
    // The last winner doubles as the round-robin pointer: both update only on a transfer.
    logic [LOG_NUM_IN-1:0] owner_q, owner_d;

    logic                  can_accept;
    logic                  grant_valid;
    logic [LOG_NUM_IN-1:0] grant_idx;
    logic [FLIT_WIDTH-1:0] grant_flit;
    logic                  xfer;
    int unsigned           idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = owner_q;
        idx         = 0;
        if (locked_q) begin
            grant_valid = 1'b1;
        end else begin
            // Walk downward so the candidate nearest to owner+1 is assigned last and wins.
            for (int unsigned k = NUM_IN; k >= 1; k--) begin
                idx = (32'(owner_q) + k) % NUM_IN;
                if (in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = LOG_NUM_IN'(idx);
                end
            end
        end
    end

    always_comb begin
        can_accept = !full_q || out_ready;
        in_ready   = '0;
        if (rst_n && grant_valid && can_accept) begin
            in_ready[grant_idx] = 1'b1;
        end
        grant_flit = in_data[grant_idx*FLIT_WIDTH +: FLIT_WIDTH];
        xfer       = |(in_valid & in_ready);
    end

    always_comb begin
        data_d   = data_q;
        full_d   = full_q;
        locked_d = locked_q;
        owner_d  = owner_q;
        if (xfer) begin
            data_d   = grant_flit;
            full_d   = 1'b1;
            owner_d  = grant_idx;
            locked_d = grant_flit[1];
        end else if (out_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            full_q   <= 1'b0;
            locked_q <= 1'b0;
            owner_q  <= '0;
        end else begin
            full_q   <= full_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end

    // Slot contents are meaningless while empty, so the data register carries no reset.
    always_ff @(negedge clk) begin
        data_q <= data_d;
    end

    assign out_data   = data_q;
    assign out_valid  = full_q;
    assign locked     = locked_q;
    assign lock_owner = owner_q;

endmodule

// File: tb/tb_flit_stream_arbiter.sv
// Self-checking bench for flit_stream_arbiter: directed scenarios plus randomized traffic
// checked against a message-level reference model.
module tb_flit_stream_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned FW = 16;

    logic            clk;
    logic            rst_n;
    logic [N*FW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [FW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            locked;
    logic [1:0]      lock_owner;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_full = 0;
    bit          m_lock = 0;
    int          m_own  = 0;
    logic [15:0] m_data = '0;
    int          m_grant;
    logic [3:0]  exp_ready;

    flit_stream_arbiter #(
        .NUM_IN     (N),
        .LOG_NUM_IN (2),
        .FLIT_WIDTH (FW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .locked     (locked),
        .lock_owner (lock_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [13:0] pay, input bit nff, input bit idle);
        return {pay, nff, idle};
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] f0, input logic [15:0] f1,
                                          input logic [15:0] f2, input logic [15:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    // Spec-level choice: locked owner keeps the grant, else first valid after the last winner.
    function automatic int model_pick(input logic [3:0] vld);
        if (m_lock) return m_own;
        for (int k = 1; k <= 4; k++) begin
            if (vld[(m_own + k) % 4]) return (m_own + k) % 4;
        end
        return -1;
    endfunction

    task automatic drive(input bit rst, input logic [3:0] vld, input logic [63:0] dat,
                         input bit ordy);
        @(posedge clk);
        #1;
        rst_n     = rst;
        in_valid  = vld;
        in_data   = dat;
        out_ready = ordy;
        m_grant   = model_pick(vld);
        exp_ready = 4'b0000;
        if (rst && m_grant >= 0 && (!m_full || ordy)) exp_ready[m_grant] = 1'b1;
        #1;
    endtask

    task automatic settle();
        logic [15:0] f;
        @(negedge clk);
        if (!rst_n) begin
            m_full = 0;
            m_lock = 0;
            m_own  = 0;
        end else if (m_grant >= 0 && exp_ready[m_grant] && in_valid[m_grant]) begin
            f      = in_data[m_grant*16 +: 16];
            m_data = f;
            m_full = 1;
            m_own  = m_grant;
            m_lock = f[1];
        end else if (out_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 4'b0000, '0, 0);
        settle();
    endtask

    task automatic test_reset();
        logic [63:0] d;
        d = pack4(mk(0, 0, 0), mk(1, 0, 0), mk(2, 0, 0), mk(3, 0, 0));
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b1111, d, 1);
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL reset_ready cycle %0d: got %b want 0000", c, in_ready);
            end
            settle();
            total++;
            if (out_valid !== 1'b0 || locked !== 1'b0 || lock_owner !== 2'd0) begin
                bad++;
                $display("FAIL reset_state cycle %0d: got valid=%b locked=%b owner=%0d want 0 0 0",
                         c, out_valid, locked, lock_owner);
            end
        end
        drive(1, 4'b1111, d, 1);
        total++;
        if (in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL reset_first_grant: got %b want 0010", in_ready);
        end
        settle();
        total++;
        if (out_valid !== 1'b1 || out_data !== mk(1, 0, 0)) begin
            bad++;
            $display("FAIL reset_first_flit: got valid=%b data=%h want 1 %h",
                     out_valid, out_data, mk(1, 0, 0));
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        int         wi;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 4'b1111, pack4(mk(0, 0, 0), mk(1, 0, 0), mk(2, 0, 0), mk(3, 0, 0)), 1);
            wi   = (k + 1) % 4;
            want = 4'b0001 << wi;
            total++;
            if (in_ready !== want) begin
                bad++;
                $display("FAIL rr_ready step %0d: got %b want %b", k, in_ready, want);
            end
            settle();
            total++;
            if (out_valid !== 1'b1 || out_data[15:2] !== 14'(wi)) begin
                bad++;
                $display("FAIL rr_order step %0d: got valid=%b payload=%0d want 1 %0d",
                         k, out_valid, out_data[15:2], wi);
            end
        end
    endtask

    task automatic test_message_lock();
        logic [3:0]  vld [5];
        logic [15:0] f2 [5];
        logic [3:0]  want_rdy [5];
        bit          want_lk [5];
        bit          want_ov [5];
        logic [15:0] want_out [5];
        vld      = '{4'b0100, 4'b1011, 4'b1111, 4'b1111, 4'b1011};
        f2       = '{mk(20, 1, 0), mk(0, 0, 0), mk(21, 1, 0), mk(22, 0, 0), mk(0, 0, 0)};
        want_rdy = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        want_lk  = '{1, 1, 1, 0, 0};
        want_ov  = '{1, 0, 1, 1, 1};
        want_out = '{mk(20, 1, 0), mk(0, 0, 0), mk(21, 1, 0), mk(22, 0, 0), mk(13, 0, 0)};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            drive(1, vld[s], pack4(mk(10, 0, 0), mk(11, 0, 0), f2[s], mk(13, 0, 0)), 1);
            total++;
            if (in_ready !== want_rdy[s]) begin
                bad++;
                $display("FAIL lock_ready step %0d: got %b want %b", s, in_ready, want_rdy[s]);
            end
            settle();
            total++;
            if (locked !== want_lk[s] || out_valid !== want_ov[s] ||
                (want_ov[s] && out_data !== want_out[s])) begin
                bad++;
                $display("FAIL lock_out step %0d: got lk=%b v=%b d=%h want lk=%b v=%b d=%h",
                         s, locked, out_valid, out_data, want_lk[s], want_ov[s], want_out[s]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, 4'b0001, pack4(mk(5, 0, 0), '0, '0, '0), 0);
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL bp_first_ready: got %b want 0001", in_ready);
        end
        settle();
        for (int c = 0; c < 5; c++) begin
            drive(1, 4'b0001, pack4(mk(6, 0, 0), '0, '0, '0), 0);
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_stall_ready cycle %0d: got %b want 0000", c, in_ready);
            end
            settle();
            total++;
            if (out_valid !== 1'b1 || out_data !== mk(5, 0, 0)) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: got v=%b d=%h want 1 %h",
                         c, out_valid, out_data, mk(5, 0, 0));
            end
        end
        drive(1, 4'b0001, pack4(mk(6, 0, 0), '0, '0, '0), 1);
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL bp_reload_ready: got %b want 0001", in_ready);
        end
        settle();
        total++;
        if (out_valid !== 1'b1 || out_data !== mk(6, 0, 0)) begin
            bad++;
            $display("FAIL bp_reload: got v=%b d=%h want 1 %h", out_valid, out_data, mk(6, 0, 0));
        end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        drive(1, 4'b0010, pack4('0, mk(7, 1, 0), '0, '0), 0);
        settle();
        total++;
        if (locked !== 1'b1 || out_valid !== 1'b1 || lock_owner !== 2'd1) begin
            bad++;
            $display("FAIL midrst_lock: got lk=%b v=%b own=%0d want 1 1 1",
                     locked, out_valid, lock_owner);
        end
        drive(0, 4'b0010, pack4('0, mk(8, 1, 0), '0, '0), 0);
        total++;
        if (in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_ready: got %b want 0000", in_ready);
        end
        settle();
        total++;
        if (locked !== 1'b0 || out_valid !== 1'b0 || lock_owner !== 2'd0) begin
            bad++;
            $display("FAIL midrst_clear: got lk=%b v=%b own=%0d want 0 0 0",
                     locked, out_valid, lock_owner);
        end
        drive(1, 4'b1000, pack4('0, '0, '0, mk(9, 0, 0)), 1);
        total++;
        if (in_ready !== 4'b1000) begin
            bad++;
            $display("FAIL midrst_regrant: got %b want 1000", in_ready);
        end
        settle();
        total++;
        if (out_valid !== 1'b1 || out_data !== mk(9, 0, 0) || locked !== 1'b0) begin
            bad++;
            $display("FAIL midrst_new_flit: got v=%b d=%h lk=%b want 1 %h 0",
                     out_valid, out_data, locked, mk(9, 0, 0));
        end
    endtask

    task automatic test_idle_token();
        logic [15:0] f;
        f = mk(14'h2A, 0, 1);
        do_reset();
        drive(1, 4'b0001, pack4(f, '0, '0, '0), 1);
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL idle_ready: got %b want 0001", in_ready);
        end
        settle();
        total++;
        if (out_valid !== 1'b1 || out_data !== f || locked !== 1'b0) begin
            bad++;
            $display("FAIL idle_pass: got v=%b d=%h lk=%b want 1 %h 0",
                     out_valid, out_data, locked, f);
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [15:0] f;
        bit          rst;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                f    = 16'($urandom);
                f[1] = ($urandom % 3) == 0;
                d[i*16 +: 16] = f;
            end
            rst = ($urandom % 40) != 0;
            drive(rst, 4'($urandom), d, ($urandom % 4) != 0);
            total++;
            if (in_ready !== exp_ready) begin
                bad++;
                $display("FAIL rand_ready cycle %0d: got %b want %b", n, in_ready, exp_ready);
            end
            settle();
            total++;
            if (out_valid !== m_full || locked !== m_lock || lock_owner !== 2'(m_own) ||
                (m_full && out_data !== m_data)) begin
                bad++;
                $display("FAIL rand_state cycle %0d: got v=%b lk=%b own=%0d d=%h want %b %b %0d %h",
                         n, out_valid, locked, lock_owner, out_data, m_full, m_lock, m_own,
                         m_data);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_message_lock();
        test_backpressure();
        test_reset_mid_message();
        test_idle_token();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
